// File: rtl/sock_order_dispatcher_if.sv
// Order and counter-condition bundle between the order source, the dispatcher
// and the sock-factory package counters.
interface sock_order_dispatcher_if #(
    parameter int unsigned QTY_W = 4
);
    logic             ord_valid;
    logic             ord_ready;
    logic [2:0]       ord_type;
    logic [1:0]       ord_size;
    logic [QTY_W-1:0] ord_qty;
    logic             hold;
    logic             PH;
    logic             SR;
    logic [2:0]       T;
    logic [1:0]       PLS;
    logic             CO;
    logic [QTY_W-1:0] pkg_cnt;
    logic             busy;
    logic             done;
    logic             err;

    // Dispatcher side
    modport master (
        input  ord_valid, ord_type, ord_size, ord_qty, hold, CO,
        output ord_ready, PH, SR, T, PLS, pkg_cnt, busy, done, err
    );

    // Order source / counter side
    modport slave (
        output ord_valid, ord_type, ord_size, ord_qty, hold, CO,
        input  ord_ready, PH, SR, T, PLS, pkg_cnt, busy, done, err
    );
endinterface

// File: rtl/sock_order_dispatcher.sv
// Order-side initiator for the sock-factory package counters: drives PH/SR/T/PLS
// while an order runs and counts CO pulses. Optional RUN watchdog: SOCK_DISPATCH_TIMEOUT_EN.
module sock_order_dispatcher #(
    parameter int unsigned QTY_W = 4
`ifdef SOCK_DISPATCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 8
`endif
) (
    input logic                       clk,
    input logic                       reset,
    sock_order_dispatcher_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE,
        ERR
    } state_t;

    state_t           state;
    logic [QTY_W-1:0] qty_q;
    logic [QTY_W-1:0] cnt_inc_c;

    assign cnt_inc_c = bus.pkg_cnt + QTY_W'(1);

`ifdef SOCK_DISPATCH_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    // Single-process FSM; outputs are loaded together with the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            qty_q         <= '0;
            bus.ord_ready <= 1'b1;
            bus.PH        <= 1'b0;
            bus.SR        <= 1'b0;
            bus.T         <= 3'd0;
            bus.PLS       <= 2'd0;
            bus.pkg_cnt   <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
`ifdef SOCK_DISPATCH_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ord_valid) begin
                        qty_q         <= bus.ord_qty;
                        bus.pkg_cnt   <= '0;
                        bus.ord_ready <= 1'b0;
                        if (bus.ord_qty != '0) begin
                            state    <= RUN;
                            bus.PH   <= 1'b1;
                            bus.SR   <= 1'b1;
                            bus.T    <= bus.ord_type;
                            bus.PLS  <= bus.ord_size;
                            bus.busy <= 1'b1;
`ifdef SOCK_DISPATCH_TIMEOUT_EN
                            tmo_cnt  <= '0;
`endif
                        end else begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (bus.CO) begin
                        bus.pkg_cnt <= cnt_inc_c;
`ifdef SOCK_DISPATCH_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                        // Completion wins over a pause request on the same package
                        if (cnt_inc_c == qty_q) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                            bus.PH   <= 1'b0;
                            bus.SR   <= 1'b0;
                            bus.T    <= 3'd0;
                            bus.PLS  <= 2'd0;
                            bus.busy <= 1'b0;
                        end else if (bus.hold) begin
                            state  <= PAUSE;
                            bus.PH <= 1'b0;
                            bus.SR <= 1'b0;
                        end
                    end
`ifdef SOCK_DISPATCH_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        state    <= ERR;
                        bus.err  <= 1'b1;
                        bus.PH   <= 1'b0;
                        bus.SR   <= 1'b0;
                        bus.T    <= 3'd0;
                        bus.PLS  <= 2'd0;
                        bus.busy <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end

                // T/PLS stay latched so the condition returns unchanged on resume
                PAUSE: begin
                    if (!bus.hold) begin
                        state  <= RUN;
                        bus.PH <= 1'b1;
                        bus.SR <= 1'b1;
`ifdef SOCK_DISPATCH_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end

                DONE: begin
                    state         <= IDLE;
                    bus.ord_ready <= 1'b1;
                end

                ERR: begin
                    state <= ERR;
                end

                default: begin
                    state         <= IDLE;
                    bus.ord_ready <= 1'b1;
                    bus.PH        <= 1'b0;
                    bus.SR        <= 1'b0;
                    bus.T         <= 3'd0;
                    bus.PLS       <= 2'd0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sock_order_dispatcher.sv
// Directed bench for sock_order_dispatcher with a behavioural package-counter model.
module tb_sock_order_dispatcher;

    localparam int unsigned QTY_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sock_order_dispatcher_if #(.QTY_W(QTY_W)) bus ();

    sock_order_dispatcher #(.QTY_W(QTY_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Counter model: 000->001->010->111 while its condition holds, CO in 111
    logic [2:0] cst;
    logic [2:0] m_type = 3'd0;
    logic [1:0] m_size = 2'd0;
    logic       co_en = 1'b1;
    logic       cond;

    assign cond   = bus.PH && bus.SR && (bus.T == m_type) && (bus.PLS == m_size);
    assign bus.CO = co_en && cond && (cst == 3'b111);

    always @(posedge clk or negedge reset) begin
        if (!reset) cst <= 3'b000;
        else if (!cond) cst <= 3'b000;
        else begin
            case (cst)
                3'b000:  cst <= 3'b001;
                3'b001:  cst <= 3'b010;
                3'b010:  cst <= 3'b111;
                default: cst <= 3'b000;
            endcase
        end
    end

    typedef struct {
        logic [2:0] typ;
        logic [1:0] siz;
        int         qty;
        int         hold_on;
        int         hold_off;
        int         e_ph;
        int         e_co;
        int         e_first;
        int         e_last;
        int         e_done;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic accept(input logic [2:0] typ, input logic [1:0] siz, input int qty, output int k);
        @(negedge clk);
        bus.ord_valid = 1'b1;
        bus.ord_type  = typ;
        bus.ord_size  = siz;
        bus.ord_qty   = QTY_W'(qty);
        @(posedge clk);
        @(negedge clk);
        bus.ord_valid = 1'b0;
        k = cyc;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int k;
        int ph_n = 0, co_n = 0, first = -1, last = -1, done_off = -1, done_n = 0;
        int tp_bad = 0, pkg_done = -1, tp_done = -1, busy_done = -1, rdy_after = -1;
        m_type = v.typ;
        m_size = v.siz;
        chk({tag, " ready_before"}, int'(bus.ord_ready), 1);
        accept(v.typ, v.siz, v.qty, k);
        for (int off = 0; off < 4 * v.qty + 30; off++) begin
            if (off == v.hold_on)  bus.hold = 1'b1;
            if (off == v.hold_off) bus.hold = 1'b0;
            if (bus.PH) ph_n++;
            if (bus.CO) begin
                co_n++;
                if (first < 0) first = off;
                last = off;
            end
            if (bus.busy && (bus.T != v.typ || bus.PLS != v.siz)) tp_bad++;
            if (bus.done) begin
                done_n++;
                if (done_off < 0) begin
                    done_off  = off;
                    pkg_done  = int'(bus.pkg_cnt);
                    tp_done   = int'({bus.T, bus.PLS});
                    busy_done = int'(bus.busy);
                end
            end
            if (done_off >= 0 && off == done_off + 1) begin
                rdy_after = int'(bus.ord_ready);
                break;
            end
            @(negedge clk);
        end
        bus.hold = 1'b0;
        chk({tag, " done_cycle"}, done_off, v.e_done);
        chk({tag, " ph_cycles"}, ph_n, v.e_ph);
        chk({tag, " co_count"}, co_n, v.e_co);
        chk({tag, " first_co"}, first, v.e_first);
        chk({tag, " last_co"}, last, v.e_last);
        chk({tag, " pkg_cnt"}, pkg_done, v.qty);
        chk({tag, " t_pls_held"}, tp_bad, 0);
        chk({tag, " t_pls_at_done"}, tp_done, 0);
        chk({tag, " busy_at_done"}, busy_done, 0);
        chk({tag, " done_pulses"}, done_n, 1);
        chk({tag, " ready_after"}, rdy_after, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int saw_done;

        //        typ     siz    qty hon hoff  ph  co  1st last done
        vecs[0] = '{3'b100, 2'b10,  3, -1, -1,  12,  3,  3, 11, 12};
        vecs[1] = '{3'b011, 2'b01,  0, -1, -1,   0,  0, -1, -1,  0};
        vecs[2] = '{3'b111, 2'b11,  1, -1, -1,   4,  1,  3,  3,  4};
        vecs[3] = '{3'b000, 2'b00, 15, -1, -1,  60, 15,  3, 59, 60};
        vecs[4] = '{3'b010, 2'b10,  4,  1,  8,  16,  4,  3, 20, 21};
        vecs[5] = '{3'b001, 2'b01,  2,  7,  9,   8,  2,  3,  7,  8};
        vecs[6] = '{3'b101, 2'b00,  2,  4,  6,   8,  2,  3,  7,  8};

        bus.ord_valid = 1'b0;
        bus.ord_type  = 3'd0;
        bus.ord_size  = 2'd0;
        bus.ord_qty   = '0;
        bus.hold      = 1'b0;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset ord_ready", int'(bus.ord_ready), 1);
        chk("reset drive", int'({bus.PH, bus.SR, bus.T, bus.PLS}), 0);
        chk("reset pkg_cnt", int'(bus.pkg_cnt), 0);
        chk("reset status", int'({bus.busy, bus.done, bus.err}), 0);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a qty=2 order
        m_type = 3'b110;
        m_size = 2'b01;
        accept(3'b110, 2'b01, 2, k);
        repeat (5) @(negedge clk);
        chk("midreset pkg_before", int'(bus.pkg_cnt), 1);
        chk("midreset ph_before", int'(bus.PH), 1);
        reset = 1'b0;
        #1;
        chk("midreset ph", int'(bus.PH), 0);
        chk("midreset pkg_cnt", int'(bus.pkg_cnt), 0);
        chk("midreset busy", int'(bus.busy), 0);
        saw_done = int'(bus.done);
        repeat (3) begin
            @(negedge clk);
            saw_done += int'(bus.done);
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            saw_done += int'(bus.done);
        end
        chk("midreset no_done", saw_done, 0);
        run_vec(vecs[2], "after_reset");

        // CO never arrives
        co_en  = 1'b0;
        m_type = 3'b011;
        m_size = 2'b11;
        accept(3'b011, 2'b11, 3, k);
        repeat (7) @(negedge clk);
        chk("stall ph_at_7", int'(bus.PH), 1);
        chk("stall err_at_7", int'(bus.err), 0);
        @(negedge clk);
`ifdef SOCK_DISPATCH_TIMEOUT_EN
        chk("timeout err", int'(bus.err), 1);
        chk("timeout ph", int'(bus.PH), 0);
        chk("timeout ready", int'(bus.ord_ready), 0);
        repeat (12) @(negedge clk);
        chk("timeout err_sticky", int'(bus.err), 1);
        chk("timeout ready_sticky", int'(bus.ord_ready), 0);
`else
        chk("stall err", int'(bus.err), 0);
        chk("stall ph", int'(bus.PH), 1);
        repeat (12) @(negedge clk);
        chk("stall err_late", int'(bus.err), 0);
        chk("stall ph_late", int'(bus.PH), 1);
`endif
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        co_en = 1'b1;
        @(negedge clk);
        chk("recover err", int'(bus.err), 0);
        chk("recover ready", int'(bus.ord_ready), 1);
        run_vec(vecs[0], "recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sock_order_dispatcher.md
# sock_order_dispatcher

Order-side initiator for the sock-factory package counters. Accepts a production order (sock type, size, number of packages), drives the counters' PH/SR/T/PLS condition lines steadily while the order runs, counts the CO package pulses returned, and finishes when the requested number of packages has been counted. One dispatcher fronts all type/size counters in parallel. Only the counter whose T/PLS decode matches advances.

## Interface
- QTY_W, 4, width of order quantity and package counter
- TIMEOUT, 8, max RUN cycles without a CO before error (with the timeout feature compiled in; min 5)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ord_valid  in  1  order offered
- ord_ready  out  1  dispatcher can accept an order
- ord_type  in  3  sock type code, copied to T
- ord_size  in  2  size code, copied to PLS
- ord_qty  in  QTY_W  packages requested
- hold  in  1  pause request, honoured only at package boundaries
- PH  out  1  production-enable line to counters
- SR  out  1  supply-ready line to counters
- T  out  3  type code to counters
- PLS  out  2  size code to counters
- CO  in  1  package-complete pulse from the selected counter
- pkg_cnt  out  QTY_W  packages counted for the current/last order
- busy  out  1  order in progress (RUN or PAUSE)
- done  out  1  one-cycle pulse when an order completes
- err  out  1  sticky timeout error

## Operation
- All outputs registered. Reset (reset=0) forces IDLE. PH=SR=0, T=0, PLS=0, pkg_cnt=0, busy=0, done=0, err=0, ord_ready=1 after release.
- States: IDLE, RUN, PAUSE, DONE, ERR.
- IDLE: ord_ready=1. ord_valid=1 latches type/size/qty and clears pkg_cnt.
  - If qty≠0: go to RUN.
  - If qty=0: go to DONE; PH never asserts.
- RUN: PH=SR=1, T=latched type, PLS=latched size, held constant every cycle. Each cycle with CO=1 increments pkg_cnt. Transitions are evaluated in the CO cycle:
  - If the new pkg_cnt equals qty: go to DONE. Completion takes priority over hold.
  - Else if hold=1: go to PAUSE.
- PH is never dropped mid-package, because a matching counter resets its partial count when its condition drops. Hold asserted without CO has no effect until the next CO.
- PAUSE: PH=SR=0, T/PLS keep the latched values, busy=1. Returns to RUN the cycle after hold=0.
- DONE: one cycle. done=1, PH=SR=0, T=PLS=0, busy=0. Then IDLE. pkg_cnt holds its final value until the next order is accepted.
- CO outside RUN is ignored.
- pkg_cnt does not wrap; qty caps it.
- ERR: all drive lines 0, err=1, ord_ready=0. Exited only by reset.

## Timing
- Order accepted at edge k (ord_valid sampled in cycle k-1). PH/SR/T/PLS valid from cycle k.
- Conforming counter sequence: states 000→001→010→111, with CO high in state 111. First CO appears in cycle k+3, and one CO follows every 4 cycles while PH is held.
- Order of qty N: last CO is in cycle k+4N-1, done pulses in cycle k+4N, ord_ready=1 in cycle k+4N+1.
- Resume from PAUSE restarts the counter at 000, so the next CO arrives 3 cycles after PH returns.
- Reset asserted mid-order: outputs go to their reset values immediately (asynchronously). The order is lost and no done pulse is produced.

## Configuration
- SOCK_DISPATCH_TIMEOUT_EN defined:
  - A cycle counter runs in RUN. It clears on entry to RUN and on each CO.
  - When it reaches TIMEOUT with no CO, the next state is ERR and err=1.
  - PAUSE cycles are not counted.
- Not defined: no counter; err is tied 0 and ERR is unreachable.

## Test plan
- Order type=100, size=10, qty=3, with a behavioural counter model → PH high 12 cycles, CO in cycles k+3/k+7/k+11, done in k+12, pkg_cnt=3.
- qty=0 → done one cycle after acceptance, PH never high, pkg_cnt=0.
- qty=4, hold raised in cycle k+1 and held → PH stays high until CO at k+3, PAUSE from k+4. Release hold → next CO 3 cycles after PH returns; final pkg_cnt=4.
- Hold raised in the same cycle as the final CO → DONE, not PAUSE.
- reset=0 at cycle k+5 of a qty=2 order → PH=0, pkg_cnt=0, busy=0 immediately, no done pulse. After release, a new order is accepted.
- With SOCK_DISPATCH_TIMEOUT_EN and TIMEOUT=8, CO held 0 → err=1 and PH=0 after 8 RUN cycles, persists until reset. Without the macro → PH stays high, err stays 0.
